// File: rtl/cpu_define.sv
// Shared core definitions: bus widths, the memory response payload and a byte-merge helper.
// The optional err field is present only when MEM_RSP_ERR_EN is defined.
package cpu_define;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DATA_BYTE  = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] data;
`ifdef MEM_RSP_ERR_EN
        logic                  err;
`endif
    } mem_rsp_t;

    // Replace the bytes of old_word selected by strb with the matching bytes of wdata.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_BYTE-1:0]  strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(DATA_BYTE); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rsp_delay_pipe.sv
// Fixed-depth response delay line; every stage is cleared by the asynchronous reset so
// in-flight responses are discarded when rst_n falls.
module rsp_delay_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  T     din,
    output T     dout
);

    T stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_rsp_ctrl.sv
// Word-addressed memory behind the core's fetch and load/store ports, fixed response latency.
// Define MEM_RSP_ERR_EN to add ifu_rsp_err/lsu_rsp_err (out-of-range or misaligned request).
module mem_rsp_ctrl
    import cpu_define::*;
#(
    parameter int unsigned           MEM_DEPTH   = 4096,
    parameter int unsigned           RSP_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_addr_vld,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_data_vld,
    output logic [DATA_WIDTH-1:0] ifu_rsp_data,
    input  logic                  lsu_req_vld,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_data,
    input  logic [DATA_BYTE-1:0]  lsu_req_data_strobe,
    output logic                  lsu_rsp_vld,
    output logic [DATA_WIDTH-1:0] lsu_rsp_data
`ifdef MEM_RSP_ERR_EN
    ,
    output logic                  ifu_rsp_err,
    output logic                  lsu_rsp_err
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W = $clog2(DATA_BYTE);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] ifu_word;
    logic [ADDR_WIDTH-1:0] lsu_word;
    logic [IDX_W-1:0]      ifu_idx;
    logic [IDX_W-1:0]      lsu_idx;
    logic                  ifu_in_range;
    logic                  lsu_in_range;
    logic                  lsu_store;
    logic [DATA_WIDTH-1:0] ifu_rd;
    logic [DATA_WIDTH-1:0] lsu_rd;

    mem_rsp_t ifu_rsp_in;
    mem_rsp_t ifu_rsp_out;
    mem_rsp_t lsu_rsp_in;
    mem_rsp_t lsu_rsp_out;

    // Addresses below BASE_ADDR wrap to huge word indices and so fall out of range.
    assign ifu_word     = (ifu_req_addr - BASE_ADDR) >> OFF_W;
    assign lsu_word     = (lsu_req_addr - BASE_ADDR) >> OFF_W;
    assign ifu_in_range = ifu_word < ADDR_WIDTH'(MEM_DEPTH);
    assign lsu_in_range = lsu_word < ADDR_WIDTH'(MEM_DEPTH);
    assign ifu_idx      = ifu_word[IDX_W-1:0];
    assign lsu_idx      = lsu_word[IDX_W-1:0];
    assign lsu_store    = lsu_req_vld && (|lsu_req_data_strobe);

    // Reads see the array before this edge's store lands (read-before-write).
    assign ifu_rd = ifu_in_range ? mem[ifu_idx] : '0;
    assign lsu_rd = lsu_in_range ? mem[lsu_idx] : '0;

    always_ff @(posedge clk) begin
        if (lsu_store && lsu_in_range) begin
            mem[lsu_idx] <= merge_bytes(mem[lsu_idx], lsu_req_data, lsu_req_data_strobe);
        end
    end

    always_comb begin
        ifu_rsp_in      = '0;
        ifu_rsp_in.vld  = ifu_req_addr_vld;
        ifu_rsp_in.data = ifu_req_addr_vld ? ifu_rd : '0;
`ifdef MEM_RSP_ERR_EN
        ifu_rsp_in.err  = ifu_req_addr_vld && (!ifu_in_range || (|ifu_req_addr[OFF_W-1:0]));
`endif
    end

    always_comb begin
        lsu_rsp_in      = '0;
        lsu_rsp_in.vld  = lsu_req_vld;
        lsu_rsp_in.data = (lsu_req_vld && !lsu_store) ? lsu_rd : '0;
`ifdef MEM_RSP_ERR_EN
        lsu_rsp_in.err  = lsu_req_vld && (!lsu_in_range || (|lsu_req_addr[OFF_W-1:0]));
`endif
    end

    rsp_delay_pipe #(
        .DEPTH (RSP_LATENCY),
        .T     (mem_rsp_t)
    ) u_ifu_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ifu_rsp_in),
        .dout  (ifu_rsp_out)
    );

    rsp_delay_pipe #(
        .DEPTH (RSP_LATENCY),
        .T     (mem_rsp_t)
    ) u_lsu_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (lsu_rsp_in),
        .dout  (lsu_rsp_out)
    );

    assign ifu_rsp_data_vld = ifu_rsp_out.vld;
    assign ifu_rsp_data     = ifu_rsp_out.data;
    assign lsu_rsp_vld      = lsu_rsp_out.vld;
    assign lsu_rsp_data     = lsu_rsp_out.data;
`ifdef MEM_RSP_ERR_EN
    assign ifu_rsp_err      = ifu_rsp_out.err;
    assign lsu_rsp_err      = lsu_rsp_out.err;
`endif

endmodule

// File: doc/mem_rsp_ctrl.md
Name: mem_rsp_ctrl

Overview:
- Memory-side responder for the core's instruction-fetch and load/store request interfaces; the far end of the ifu_req/ifu_rsp and lsu_req/lsu_rsp ports.
- Holds a word-addressed memory array and accepts one request per cycle per port, with no backpressure.
- Returns read data after a fixed, parameterised latency.
- Used as the simulation and FPGA memory behind the core.

Parameters:
- MEM_DEPTH, 4096: number of DATA_WIDTH words in the array; power of 2.
- RSP_LATENCY, 1: cycles from request to response; legal range 1..8.
- BASE_ADDR, 0: byte address of word 0. ADDR_WIDTH and DATA_WIDTH come from cpu_define.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_addr_vld  in  1  fetch request valid
- ifu_req_addr  in  ADDR_WIDTH  fetch byte address
- ifu_rsp_data_vld  out  1  fetch response valid
- ifu_rsp_data  out  DATA_WIDTH  fetched word
- lsu_req_vld  in  1  load/store request valid
- lsu_req_addr  in  ADDR_WIDTH  load/store byte address
- lsu_req_data  in  DATA_WIDTH  store data
- lsu_req_data_strobe  in  DATA_BYTE  byte enables; all-zero means load, non-zero means store
- lsu_rsp_vld  out  1  load/store response valid
- lsu_rsp_data  out  DATA_WIDTH  load data, or 0 for a store ack

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Values under reset: ifu_rsp_data_vld=0, ifu_rsp_data=0, lsu_rsp_vld=0, lsu_rsp_data=0, all pipeline stages cleared. The memory array is not reset.
- Address mapping: word index = (addr - BASE_ADDR) >> log2(DATA_BYTE). The low log2(DATA_BYTE) bits are ignored, so misaligned addresses access the containing word.
- Out of range: an index >= MEM_DEPTH (including addr < BASE_ADDR after wrap) reads as 0. A store to such an index is dropped.
- Accept: a request with vld=1 on a rising edge is accepted unconditionally. There is no ready signal.
- Read sampling: read data is sampled from the array at the accept edge.
- Store: on the accept edge, bytes with strobe[i]=1 are written (byte lane i = data[8i+7:8i]); other bytes are unchanged.
- Latency: a request accepted at edge N produces rsp_vld=1 with its data for exactly one cycle after edge N+RSP_LATENCY-1. For RSP_LATENCY=1, the response is registered and visible in the cycle after the request.
- Pipelining: back-to-back requests on every cycle give back-to-back responses, in order, one per request, never merged or dropped.
- Data when idle: response data is 0 whenever rsp_vld=0.
- Stores: every store yields one lsu_rsp_vld pulse with lsu_rsp_data=0, on the same latency as loads.
- Same-cycle collision: an LSU store and an IFU or LSU read of the same word on the same edge cannot occur on one port. For an IFU read and an LSU store, the IFU receives the pre-store word (read-before-write).
- Store then load: a store at edge N followed by a load of the same word at edge N+1 returns the new data.
- Reset mid-operation: all in-flight responses are discarded and no response is issued for them. Stores already accepted remain in the array.

Optional Feature:
- Macro: MEM_RSP_ERR_EN.
- When defined, the block adds output ports ifu_rsp_err (1) and lsu_rsp_err (1).
- Each err flag is asserted together with its rsp_vld when the request was out of range, or when its address low bits were non-zero (misaligned).
- Both err flags reset to 0 and are 0 when rsp_vld=0.
- When the macro is undefined, these ports and their pipeline bits do not exist, and behaviour is otherwise identical.

Decomposition:
- cpu_define (shared package) holds ADDR_WIDTH, DATA_WIDTH and DATA_BYTE, plus a new typedef mem_rsp_t {vld, data, err}.
- Sub-module rsp_delay_pipe: parameterised by depth RSP_LATENCY and payload type mem_rsp_t, with async-reset valid bits. It is instantiated once per port.
- The array and the byte-strobe write logic stay in mem_rsp_ctrl.

Test Plan:
All cases use DATA_WIDTH=32, BASE_ADDR=0, MEM_DEPTH=4096.
- Store then load: store addr 0x10, data 0xDEADBEEF, strobe 4'hF. Then load 0x10 with RSP_LATENCY=1 → lsu_rsp_vld pulses twice; first data 0, second 0xDEADBEEF.
- Partial strobe: word 0x20 = 0x11223344; store data 0xAABBCCDD with strobe 4'b0101, then load → 0x11BB33DD.
- Streaming fetch: with RSP_LATENCY=3, fetch 0x0,0x4,0x8,0xC on consecutive cycles → four consecutive ifu_rsp_data_vld pulses, the first 3 cycles after the first request, data in order.
- Collision: IFU read 0x40 (old value 0x5) and LSU store 0x40 data 0x9 on the same edge → IFU gets 0x5; a later fetch gets 0x9.
- Out of range and errors: load 0x4000 → data 0; with MEM_RSP_ERR_EN, lsu_rsp_err=1. Load 0x42 → word 0x40 returned, err=1. A store to 0x4000 leaves memory unchanged.
- Reset mid-flight: with RSP_LATENCY=4, issue a load, then assert rst_n=0 two cycles later → no lsu_rsp_vld appears; outputs read 0 immediately on reset assertion.
